// File: rtl/id_scoreboard_pkg.sv
// Shared types for the ID-stage multi-cycle scoreboard: register bank select,
// the per-entry record and the default depth.
package id_scoreboard_pkg;

  typedef enum logic {
    BANK_INT = 1'b0,
    BANK_FP  = 1'b1
  } reg_bank_mux_t;

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [4:0]    addr;
    reg_bank_mux_t bank;
  } sb_entry_t;

  localparam int unsigned SB_DEPTH_DEFAULT = 4;

  // Integer x0 is hardwired to zero, so it is never a real producer or consumer.
  function automatic logic is_int_x0(input logic [4:0] addr, input reg_bank_mux_t bank);
    return (bank == BANK_INT) && (addr == 5'd0);
  endfunction

endpackage

// File: rtl/id_scoreboard_sb_match.sv
// Compares one register (address + bank) against every pending scoreboard entry.
// Entries flagged in excl_i are ignored (used for the completion bypass).
module id_scoreboard_sb_match
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned ISA_F = 0
) (
  input  sb_entry_t [DEPTH-1:0] entries_i,
  input  logic      [DEPTH-1:0] excl_i,
  input  logic      [4:0]       addr_i,
  input  reg_bank_mux_t         bank_i,
  output logic                  hit_o
);

  // Hit if any valid, writing, non-excluded entry targets the same register.
  always_comb begin
    hit_o = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entries_i[k].valid && entries_i[k].wen && !excl_i[k] &&
          (entries_i[k].addr == addr_i) && (entries_i[k].bank == bank_i)) begin
        hit_o = 1'b1;
      end
    end
    if (is_int_x0(addr_i, bank_i) || ((ISA_F == 0) && (bank_i == BANK_FP))) begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// In-order scoreboard for multi-cycle writers issued from ID. Tracks pending
// destinations in a FIFO, stalls ID on RAW/WAW against them, and presents the
// head entry to WB for writeback steering.
// Optional: define SCOREBOARD_CMPL_BYPASS_EN to drop the completing head entry
// from hazard matching in its completion cycle (WB must forward that result).
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned ISA_F = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       valid_id_i,
  input  logic [2:0]                 rs_used_id_i,
  input  logic [4:0]                 rs1_addr_id_i,
  input  logic [4:0]                 rs2_addr_id_i,
  input  logic [4:0]                 rs3_addr_id_i,
  input  reg_bank_mux_t              rs1_bank_id_i,
  input  reg_bank_mux_t              rs2_bank_id_i,
  input  reg_bank_mux_t              rs3_bank_id_i,
  input  logic [4:0]                 rd_addr_id_i,
  input  reg_bank_mux_t              rd_bank_id_i,
  input  logic                       rd_wen_id_i,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic                       cmpl_valid_i,
  output logic [4:0]                 cmpl_rd_addr_o,
  output reg_bank_mux_t              cmpl_rd_bank_o,
  output logic                       cmpl_wen_o,
  output logic                       stall_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       err_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  err_q, err_d;

  logic                  full, empty, do_issue, do_cmpl, new_wen;
  logic                  hit_rs1, hit_rs2, hit_rs3, hit_rd;
  logic [DEPTH-1:0]      excl;
  sb_entry_t             head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = entries_q[rd_ptr_q];

`ifdef SCOREBOARD_CMPL_BYPASS_EN
  // The head entry's result is being forwarded this cycle, so it cannot hazard.
  always_comb begin
    excl = '0;
    if (cmpl_valid_i && !empty) excl[rd_ptr_q] = 1'b1;
  end
`else
  assign excl = '0;
`endif

  id_scoreboard_sb_match #(.DEPTH(DEPTH), .ISA_F(ISA_F)) u_match_rs1 (
    .entries_i(entries_q), .excl_i(excl), .addr_i(rs1_addr_id_i), .bank_i(rs1_bank_id_i), .hit_o(hit_rs1));
  id_scoreboard_sb_match #(.DEPTH(DEPTH), .ISA_F(ISA_F)) u_match_rs2 (
    .entries_i(entries_q), .excl_i(excl), .addr_i(rs2_addr_id_i), .bank_i(rs2_bank_id_i), .hit_o(hit_rs2));
  id_scoreboard_sb_match #(.DEPTH(DEPTH), .ISA_F(ISA_F)) u_match_rs3 (
    .entries_i(entries_q), .excl_i(excl), .addr_i(rs3_addr_id_i), .bank_i(rs3_bank_id_i), .hit_o(hit_rs3));
  id_scoreboard_sb_match #(.DEPTH(DEPTH), .ISA_F(ISA_F)) u_match_rd (
    .entries_i(entries_q), .excl_i(excl), .addr_i(rd_addr_id_i), .bank_i(rd_bank_id_i), .hit_o(hit_rd));

  assign stall_o = valid_id_i &&
                   ((rs_used_id_i[0] && hit_rs1) ||
                    (rs_used_id_i[1] && hit_rs2) ||
                    (rs_used_id_i[2] && hit_rs3) ||
                    (rd_wen_id_i && hit_rd));

  // Ready ignores same-cycle completion so a full FIFO never accepts an issue.
  assign issue_ready_o = !full && !stall_o;
  assign do_issue      = issue_valid_i && issue_ready_o;
  assign do_cmpl       = cmpl_valid_i && !empty;
  assign new_wen       = rd_wen_id_i && !is_int_x0(rd_addr_id_i, rd_bank_id_i) &&
                         ((ISA_F != 0) || (rd_bank_id_i == BANK_INT));

  assign cmpl_rd_addr_o = head.valid ? head.addr : 5'd0;
  assign cmpl_rd_bank_o = head.valid ? head.bank : BANK_INT;
  assign cmpl_wen_o     = head.valid && head.wen;
  assign busy_o         = !empty;
  assign count_o        = count_q;
  assign err_o          = err_q;

  // Next-state: push on accepted issue, pop on completion, flag protocol errors.
  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    if (do_issue) begin
      entries_d[wr_ptr_q].valid = 1'b1;
      entries_d[wr_ptr_q].wen   = new_wen;
      entries_d[wr_ptr_q].addr  = rd_addr_id_i;
      entries_d[wr_ptr_q].bank  = rd_bank_id_i;
      wr_ptr_d                  = ptr_inc(wr_ptr_q);
    end
    if (do_cmpl) begin
      entries_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d                  = ptr_inc(rd_ptr_q);
    end
    case ({do_issue, do_cmpl})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if ((cmpl_valid_i && empty) || (issue_valid_i && full)) err_d = 1'b1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      entries_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard (DEPTH=4, ISA_F=1) with a queue-based
// reference model of the pending-writer list.
module tb_id_scoreboard;
  import id_scoreboard_pkg::*;

  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          valid_id;
  logic [2:0]    rs_used;
  logic [4:0]    rs1_addr, rs2_addr, rs3_addr, rd_addr;
  reg_bank_mux_t rs1_bank, rs2_bank, rs3_bank, rd_bank;
  logic          rd_wen, issue_valid, issue_ready, cmpl_valid;
  logic [4:0]    cmpl_rd_addr;
  reg_bank_mux_t cmpl_rd_bank;
  logic          cmpl_wen, stall, busy, err;
  logic [2:0]    count;

  id_scoreboard #(.DEPTH(DEPTH), .ISA_F(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_id_i(valid_id), .rs_used_id_i(rs_used),
    .rs1_addr_id_i(rs1_addr), .rs2_addr_id_i(rs2_addr), .rs3_addr_id_i(rs3_addr),
    .rs1_bank_id_i(rs1_bank), .rs2_bank_id_i(rs2_bank), .rs3_bank_id_i(rs3_bank),
    .rd_addr_id_i(rd_addr), .rd_bank_id_i(rd_bank), .rd_wen_id_i(rd_wen),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .cmpl_valid_i(cmpl_valid),
    .cmpl_rd_addr_o(cmpl_rd_addr), .cmpl_rd_bank_o(cmpl_rd_bank), .cmpl_wen_o(cmpl_wen),
    .stall_o(stall), .busy_o(busy), .count_o(count), .err_o(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]    addr;
    reg_bank_mux_t bank;
    bit            wen;
  } m_ent_t;

  m_ent_t q[$];
  bit     m_err = 0;

  function automatic bit m_hit(input logic [4:0] a, input reg_bank_mux_t b);
    if (b == BANK_INT && a == 5'd0) return 1'b0;
    foreach (q[i]) begin
`ifdef SCOREBOARD_CMPL_BYPASS_EN
      if (i == 0 && cmpl_valid) continue;
`endif
      if (q[i].wen && q[i].addr == a && q[i].bank == b) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return valid_id && ((rs_used[0] && m_hit(rs1_addr, rs1_bank)) ||
                        (rs_used[1] && m_hit(rs2_addr, rs2_bank)) ||
                        (rs_used[2] && m_hit(rs3_addr, rs3_bank)) ||
                        (rd_wen && m_hit(rd_addr, rd_bank)));
  endfunction

  // Advance one clock and apply the same cycle's effects to the model.
  task automatic tick();
    bit acc_i, acc_c, e_i, e_c;
    m_ent_t ent;
    acc_i = issue_valid && (q.size() < DEPTH) && !m_stall();
    acc_c = cmpl_valid && (q.size() > 0);
    e_i   = issue_valid && (q.size() == DEPTH);
    e_c   = cmpl_valid && (q.size() == 0);
    ent.addr = rd_addr;
    ent.bank = rd_bank;
    ent.wen  = rd_wen && !(rd_bank == BANK_INT && rd_addr == 5'd0);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      if (e_i || e_c) m_err = 1'b1;
      if (acc_i) q.push_back(ent);
      if (acc_c) void'(q.pop_front());
    end
  endtask

  task automatic set_idle();
    valid_id = 0; rs_used = 0; rd_wen = 0; issue_valid = 0; cmpl_valid = 0;
    rs1_addr = 0; rs2_addr = 0; rs3_addr = 0; rd_addr = 0;
    rs1_bank = BANK_INT; rs2_bank = BANK_INT; rs3_bank = BANK_INT; rd_bank = BANK_INT;
  endtask

  task automatic do_issue(input logic [4:0] a, input reg_bank_mux_t b);
    set_idle();
    rd_addr = a; rd_bank = b; rd_wen = 1; issue_valid = 1;
    tick();
    set_idle();
  endtask

  task automatic do_cmpl();
    set_idle();
    cmpl_valid = 1;
    tick();
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    n_vec++; if (stall !== 1'b0)       begin n_err++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    n_vec++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_vec++; if (count !== 3'd0)       begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b expected 1", issue_ready); end
    n_vec++; if (err !== 1'b0)         begin n_err++; $display("FAIL reset_err: got %0b expected 0", err); end
    n_vec++; if ({cmpl_rd_addr, cmpl_rd_bank, cmpl_wen} !== 7'd0)
      begin n_err++; $display("FAIL reset_cmpl: got %0h expected 0", {cmpl_rd_addr, cmpl_rd_bank, cmpl_wen}); end
  endtask

  task automatic test_float_raw();
    bit exp_st;
    do_issue(5'd5, BANK_FP);
    valid_id = 1; rs_used = 3'b001; rs1_addr = 5'd5; rs1_bank = BANK_FP;
    #1;
    n_vec++; if (stall !== 1'b1)  begin n_err++; $display("FAIL raw_f5_stall: got %0b expected 1", stall); end
    n_vec++; if (count !== 3'd1)  begin n_err++; $display("FAIL raw_f5_count: got %0d expected 1", count); end
    n_vec++; if (cmpl_rd_bank !== BANK_FP) begin n_err++; $display("FAIL raw_f5_bank: got %0d expected 1", cmpl_rd_bank); end
    cmpl_valid = 1;
    #1;
`ifdef SCOREBOARD_CMPL_BYPASS_EN
    exp_st = 1'b0;
`else
    exp_st = 1'b1;
`endif
    n_vec++; if (stall !== exp_st) begin n_err++; $display("FAIL raw_f5_cmpl_cycle: got %0b expected %0b", stall, exp_st); end
    tick();
    cmpl_valid = 0;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL raw_f5_release: got %0b expected 0", stall); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL raw_f5_drain: got %0d expected 0", count); end
    set_idle();
  endtask

  task automatic test_x0();
    do_issue(5'd0, BANK_INT);
    valid_id = 1; rs_used = 3'b001; rs1_addr = 5'd0; rs1_bank = BANK_INT;
    #1;
    n_vec++; if (stall !== 1'b0)    begin n_err++; $display("FAIL x0_stall: got %0b expected 0", stall); end
    n_vec++; if (cmpl_wen !== 1'b0) begin n_err++; $display("FAIL x0_wen: got %0b expected 0", cmpl_wen); end
    n_vec++; if (count !== 3'd1)    begin n_err++; $display("FAIL x0_count: got %0d expected 1", count); end
    do_cmpl();
  endtask

  task automatic test_full_err();
    for (int i = 1; i <= 4; i++) do_issue(5'(i), BANK_INT);
    #1;
    n_vec++; if (count !== 3'd4)       begin n_err++; $display("FAIL full_count: got %0d expected 4", count); end
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %0b expected 0", issue_ready); end
    n_vec++; if (err !== 1'b0)         begin n_err++; $display("FAIL full_err_pre: got %0b expected 0", err); end
    do_issue(5'd9, BANK_INT);
    #1;
    n_vec++; if (err !== 1'b1)   begin n_err++; $display("FAIL full_err_set: got %0b expected 1", err); end
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL full_ignored: got %0d expected 4", count); end
    n_vec++; if (cmpl_rd_addr !== 5'd1) begin n_err++; $display("FAIL full_head: got %0d expected 1", cmpl_rd_addr); end
    do_cmpl();
    rd_addr = 5'd5; rd_bank = BANK_INT; rd_wen = 1; issue_valid = 1; cmpl_valid = 1;
    tick();
    set_idle();
    #1;
    n_vec++; if (count !== 3'd3)        begin n_err++; $display("FAIL simul_count: got %0d expected 3", count); end
    n_vec++; if (cmpl_rd_addr !== 5'd3) begin n_err++; $display("FAIL simul_head: got %0d expected 3", cmpl_rd_addr); end
    for (int i = 0; i < 3; i++) do_cmpl();
  endtask

  task automatic test_bank_waw();
    do_issue(5'd7, BANK_INT);
    valid_id = 1; rs_used = 3'b001; rs1_addr = 5'd7; rs1_bank = BANK_FP;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL bank_diff: got %0b expected 0", stall); end
    rs_used = 3'b000; rd_addr = 5'd7; rd_bank = BANK_INT; rd_wen = 1;
    #1;
    n_vec++; if (stall !== 1'b1)       begin n_err++; $display("FAIL waw_stall: got %0b expected 1", stall); end
    n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_ready: got %0b expected 0", issue_ready); end
    do_cmpl();
  endtask

  task automatic test_cmpl_empty_reset();
    set_idle();
    rst_n = 0; tick(); rst_n = 1;
    do_cmpl();
    #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL empty_cmpl_count: got %0d expected 0", count); end
    n_vec++; if (err !== 1'b1)   begin n_err++; $display("FAIL empty_cmpl_err: got %0b expected 1", err); end
    do_issue(5'd11, BANK_INT);
    do_issue(5'd12, BANK_FP);
    #1;
    n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL pre_rst_count: got %0d expected 2", count); end
    rst_n = 0; tick(); rst_n = 1;
    #1;
    n_vec++; if (count !== 3'd0)       begin n_err++; $display("FAIL midrst_count: got %0d expected 0", count); end
    n_vec++; if (err !== 1'b0)         begin n_err++; $display("FAIL midrst_err: got %0b expected 0", err); end
    n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %0b expected 1", issue_ready); end
  endtask

  task automatic test_wraparound();
    for (int i = 1; i <= 10; i++) begin
      do_issue(5'(i), BANK_INT);
      #1;
      n_vec++; if (cmpl_rd_addr !== 5'(i)) begin n_err++; $display("FAIL wrap_head_%0d: got %0d expected %0d", i, cmpl_rd_addr, i); end
      do_cmpl();
    end
  endtask

  task automatic test_random();
    bit exp_st;
    for (int c = 0; c < 400; c++) begin
      valid_id    = ($urandom_range(0, 3) != 0);
      rs_used     = 3'($urandom_range(0, 7));
      rs1_addr    = 5'($urandom_range(0, 3));
      rs2_addr    = 5'($urandom_range(0, 3));
      rs3_addr    = 5'($urandom_range(0, 3));
      rd_addr     = 5'($urandom_range(0, 3));
      rs1_bank    = reg_bank_mux_t'($urandom_range(0, 1));
      rs2_bank    = reg_bank_mux_t'($urandom_range(0, 1));
      rs3_bank    = reg_bank_mux_t'($urandom_range(0, 1));
      rd_bank     = reg_bank_mux_t'($urandom_range(0, 1));
      rd_wen      = ($urandom_range(0, 3) != 0);
      issue_valid = ($urandom_range(0, 1) == 1);
      cmpl_valid  = ($urandom_range(0, 2) == 0);
      #1;
      exp_st = m_stall();
      n_vec++; if (stall !== exp_st) begin n_err++; $display("FAIL rnd_stall c%0d: got %0b expected %0b", c, stall, exp_st); end
      n_vec++; if (issue_ready !== ((q.size() < DEPTH) && !exp_st))
        begin n_err++; $display("FAIL rnd_ready c%0d: got %0b expected %0b", c, issue_ready, (q.size() < DEPTH) && !exp_st); end
      n_vec++; if (count !== 3'(q.size())) begin n_err++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, count, q.size()); end
      n_vec++; if (busy !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_busy c%0d: got %0b", c, busy); end
      n_vec++; if (err !== m_err) begin n_err++; $display("FAIL rnd_err c%0d: got %0b expected %0b", c, err, m_err); end
      if (q.size() > 0) begin
        n_vec++; if ({cmpl_rd_addr, cmpl_rd_bank, cmpl_wen} !== {q[0].addr, q[0].bank, q[0].wen})
          begin n_err++; $display("FAIL rnd_head c%0d: got %0h expected %0h", c, {cmpl_rd_addr, cmpl_rd_bank, cmpl_wen}, {q[0].addr, q[0].bank, q[0].wen}); end
      end else begin
        n_vec++; if ({cmpl_rd_addr, cmpl_rd_bank, cmpl_wen} !== 7'd0)
          begin n_err++; $display("FAIL rnd_head_empty c%0d: got %0h expected 0", c, {cmpl_rd_addr, cmpl_rd_bank, cmpl_wen}); end
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    rst_n = 1;
    set_idle();
    #2;
    test_reset();
    test_float_raw();
    test_x0();
    test_full_err();
    test_bank_waw();
    test_cmpl_empty_reset();
    test_wraparound();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
